// File: rtl/spi_mem_ctrl.sv
// Byte-wide memory bus to SPI SRAM bridge (mode 0, 32-bit read/write frames).
// Define SPI_MEM_CACHE_EN to add a single-entry write-through read cache.
module spi_mem_ctrl #(
  parameter int          CLK_DIV   = 1,
  parameter logic [7:0]  CMD_READ  = 8'h03,
  parameter logic [7:0]  CMD_WRITE = 8'h02
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ready,
  output logic       busy,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      r_state, w_next;
  logic [31:0] r_shift;
  logic [7:0]  r_div;
  logic        r_phase;
  logic [5:0]  r_bitcnt;
  logic        r_we;
  logic [7:0]  r_rdata;

  logic       w_accept, w_hit, w_half_end, w_bit_end, w_last;
  logic [7:0] w_rx_byte;

  assign w_accept   = (r_state == IDLE) && req;
  assign w_half_end = (r_state == SHIFT) && (r_div == DIV_LAST);
  assign w_bit_end  = w_half_end && r_phase;
  assign w_last     = w_bit_end && (r_bitcnt == 6'd31);
  assign w_rx_byte  = {r_shift[6:0], spi_miso};

`ifdef SPI_MEM_CACHE_EN
  logic       r_cvalid;
  logic [7:0] r_ctag, r_cdata, r_addr, r_wdata;

  assign w_hit = r_cvalid && (r_ctag == addr) && !we;

  // Write-through fill: the entry always mirrors the last completed SPI access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cvalid <= 1'b0;
      r_ctag   <= 8'h00;
      r_cdata  <= 8'h00;
      r_addr   <= 8'h00;
      r_wdata  <= 8'h00;
    end else begin
      if (w_accept) begin
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      if (w_last) begin
        r_cvalid <= 1'b1;
        r_ctag   <= r_addr;
        r_cdata  <= r_we ? r_wdata : w_rx_byte;
      end
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    ready    = 1'b0;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    case (r_state)
      IDLE: if (req) w_next = w_hit ? DONE : SHIFT;
      SHIFT: begin
        busy     = 1'b1;
        spi_cs_n = 1'b0;
        spi_sclk = r_phase;
        spi_mosi = r_shift[31];
        if (w_last) w_next = DONE;
      end
      DONE: begin
        ready  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // MOSI moves only on the edge that drops SCLK, so it is stable across each rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= 32'h0;
      r_div    <= 8'h00;
      r_phase  <= 1'b0;
      r_bitcnt <= 6'd0;
      r_we     <= 1'b0;
      r_rdata  <= 8'h00;
    end else if (w_accept) begin
      r_shift  <= {(we ? CMD_WRITE : CMD_READ), 8'h00, addr, (we ? wdata : 8'h00)};
      r_div    <= 8'h00;
      r_phase  <= 1'b0;
      r_bitcnt <= 6'd0;
      r_we     <= we;
`ifdef SPI_MEM_CACHE_EN
      if (w_hit) r_rdata <= r_cdata;
`endif
    end else if (r_state == SHIFT) begin
      if (w_half_end) begin
        r_div   <= 8'h00;
        r_phase <= ~r_phase;
      end else begin
        r_div   <= r_div + 8'd1;
      end
      if (w_bit_end) begin
        r_shift  <= {r_shift[30:0], spi_miso};
        r_bitcnt <= w_last ? 6'd0 : r_bitcnt + 6'd1;
      end
      if (w_last && !r_we) r_rdata <= w_rx_byte;
    end
  end

  assign rdata = r_rdata;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: CLK_DIV=1 and CLK_DIV=3 instances, each with a mode-0 SRAM model.
module tb_spi_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req1 = 1'b0, req3 = 1'b0, we = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic [7:0] rdata1, rdata3;
  logic       ready1, ready3, busy1, busy3, cs1, cs3, sclk1, sclk3, mosi1, mosi3;
  logic       miso1 = 1'b0, miso3 = 1'b0;

  spi_mem_ctrl #(.CLK_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req1), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .ready(ready1), .busy(busy1), .spi_cs_n(cs1), .spi_sclk(sclk1),
    .spi_mosi(mosi1), .spi_miso(miso1));

  spi_mem_ctrl #(.CLK_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .ready(ready3), .busy(busy3), .spi_cs_n(cs3), .spi_sclk(sclk3),
    .spi_mosi(mosi3), .spi_miso(miso3));

  // SRAM models: capture MOSI on SCLK rise, present data-phase bits after each SCLK fall.
  logic [31:0] cap1 = '0, cap3 = '0;
  int          cnt1 = 0, cnt3 = 0;
  logic [7:0]  mb1 = 8'h00, mb3 = 8'h00;

  always @(negedge cs1) begin cnt1 = 0; cap1 = '0; miso1 = 1'b0; end
  always @(posedge sclk1) if (!cs1) begin cap1 = {cap1[30:0], mosi1}; cnt1++; end
  always @(negedge sclk1) if (!cs1) miso1 = (cnt1 >= 24 && cnt1 < 32) ? mb1[3'(31 - cnt1)] : 1'b0;

  always @(negedge cs3) begin cnt3 = 0; cap3 = '0; miso3 = 1'b0; end
  always @(posedge sclk3) if (!cs3) begin cap3 = {cap3[30:0], mosi3}; cnt3++; end
  always @(negedge sclk3) if (!cs3) miso3 = (cnt3 >= 24 && cnt3 < 32) ? mb3[3'(31 - cnt3)] : 1'b0;

  int n_tot = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request; observes cycles E+1.. and reports latency, pulses, CS-low time and phase errors.
  task automatic run(input bit sel, input logic w, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] m, input int div,
                     output int lat, output int nrdy, output int cslo, output int phbad,
                     output logic bsy, output logic [7:0] rd, output logic [31:0] mo);
    logic r, c, s, prev, first;
    int   run_len;
    @(negedge clk);
    we = w; addr = a; wdata = d;
    if (sel) begin mb3 = m; req3 = 1'b1; end
    else     begin mb1 = m; req1 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    req1 = 1'b0; req3 = 1'b0;
    lat = 0; nrdy = 0; cslo = 0; phbad = 0; bsy = 1'b0; rd = 8'h00;
    first = 1'b1; prev = 1'b0; run_len = 0;
    for (int k = 1; k <= 64 * div + 10; k++) begin
      if (k > 1) @(negedge clk);
      r = sel ? ready3 : ready1;
      c = sel ? cs3 : cs1;
      s = sel ? sclk3 : sclk1;
      if (k == 1) bsy = sel ? busy3 : busy1;
      if (r) begin
        nrdy++;
        if (lat == 0) begin lat = k; rd = sel ? rdata3 : rdata1; end
      end
      if (!c) begin
        cslo++;
        if (first) begin first = 1'b0; prev = s; run_len = 1; end
        else if (s == prev) run_len++;
        else begin
          if (run_len != div) phbad++;
          prev = s; run_len = 1;
        end
      end else if (!first && run_len != 0) begin
        if (run_len != div) phbad++;
        run_len = 0;
      end
    end
    mo = sel ? cap3 : cap1;
  endtask

  typedef struct {
    logic        w;
    logic [7:0]  a, d, m;
    logic [31:0] mo;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int lat, nrdy, cslo, phbad, viol;
    logic bsy;
    logic [7:0] rd;
    logic [31:0] mo;

    tbl[0] = '{w:1'b1, a:8'h2A, d:8'hC5, m:8'h00, mo:32'h02002AC5, rd:8'h00};
    tbl[1] = '{w:1'b0, a:8'h80, d:8'hFF, m:8'h5A, mo:32'h03008000, rd:8'h5A};
    tbl[2] = '{w:1'b0, a:8'h00, d:8'h12, m:8'hA5, mo:32'h03000000, rd:8'hA5};
    tbl[3] = '{w:1'b1, a:8'hFF, d:8'h3C, m:8'h77, mo:32'h0200FF3C, rd:8'hA5};
    tbl[4] = '{w:1'b0, a:8'hFE, d:8'h00, m:8'h81, mo:32'h0300FE00, rd:8'h81};

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs1), 32'd1);
    chk("rst_rdata", 32'(rdata1), 32'h00);
    rst_n = 1'b1;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (cs1 !== 1'b1 || sclk1 !== 1'b0 || busy1 !== 1'b0 || ready1 !== 1'b0 || mosi1 !== 1'b0) viol++;
      if (cs3 !== 1'b1 || sclk3 !== 1'b0 || busy3 !== 1'b0 || ready3 !== 1'b0) viol++;
    end
    chk("idle_violations", 32'(viol), 32'd0);

    // Table-driven transactions at CLK_DIV=1
    for (int i = 0; i < 5; i++) begin
      run(1'b0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].m, 1, lat, nrdy, cslo, phbad, bsy, rd, mo);
      chk($sformatf("v%0d_mosi", i), mo, tbl[i].mo);
      chk($sformatf("v%0d_ready_cycle", i), 32'(lat), 32'd65);
      chk($sformatf("v%0d_ready_pulses", i), 32'(nrdy), 32'd1);
      chk($sformatf("v%0d_cs_low_cycles", i), 32'(cslo), 32'd64);
      chk($sformatf("v%0d_sclk_phase", i), 32'(phbad), 32'd0);
      chk($sformatf("v%0d_busy", i), 32'(bsy), 32'd1);
      chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(tbl[i].rd));
    end

    // CLK_DIV=3 read
    run(1'b1, 1'b0, 8'h80, 8'hFF, 8'hC3, 3, lat, nrdy, cslo, phbad, bsy, rd, mo);
    chk("div3_mosi", mo, 32'h03008000);
    chk("div3_ready_cycle", 32'(lat), 32'd193);
    chk("div3_ready_pulses", 32'(nrdy), 32'd1);
    chk("div3_cs_low_cycles", 32'(cslo), 32'd192);
    chk("div3_sclk_phase", 32'(phbad), 32'd0);
    chk("div3_rdata", 32'(rd), 32'hC3);

    // Reset during bit 10 of a write
    @(negedge clk);
    we = 1'b1; addr = 8'h33; wdata = 8'h99; req1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req1 = 1'b0;
    for (int k = 0; k < 200 && cnt1 < 10; k++) @(negedge clk);
    chk("abort_bitcount", 32'(cnt1), 32'd10);
    chk("abort_cs_low_before", 32'(cs1), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n_async", 32'(cs1), 32'd1);
    chk("abort_sclk", 32'(sclk1), 32'd0);
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_rdata", 32'(rdata1), 32'h00);
    viol = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready1) viol++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ready1) viol++;
    end
    chk("abort_no_ready", 32'(viol), 32'd0);
    run(1'b0, tbl[0].w, tbl[0].a, tbl[0].d, tbl[0].m, 1, lat, nrdy, cslo, phbad, bsy, rd, mo);
    chk("post_abort_mosi", mo, tbl[0].mo);
    chk("post_abort_ready_cycle", 32'(lat), 32'd65);
    chk("post_abort_cs_low_cycles", 32'(cslo), 32'd64);

`ifdef SPI_MEM_CACHE_EN
    run(1'b0, 1'b1, 8'h10, 8'h77, 8'h00, 1, lat, nrdy, cslo, phbad, bsy, rd, mo);
    chk("cache_wr_ready_cycle", 32'(lat), 32'd65);
    run(1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 1, lat, nrdy, cslo, phbad, bsy, rd, mo);
    chk("cache_hit_ready_cycle", 32'(lat), 32'd1);
    chk("cache_hit_rdata", 32'(rd), 32'h77);
    chk("cache_hit_cs_low", 32'(cslo), 32'd0);
    chk("cache_hit_busy", 32'(bsy), 32'd0);
    chk("cache_hit_pulses", 32'(nrdy), 32'd1);
    run(1'b0, 1'b0, 8'h11, 8'h00, 8'hE4, 1, lat, nrdy, cslo, phbad, bsy, rd, mo);
    chk("cache_miss_ready_cycle", 32'(lat), 32'd65);
    chk("cache_miss_rdata", 32'(rd), 32'hE4);
    chk("cache_miss_mosi", mo, 32'h03001100);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
- Bridges the Neander core's byte-wide memory bus to an external SPI SRAM (23LC512-class, SPI mode 0) through the uio pins of tt_um_cpu_leonardoaraujosantos.
- Sits directly downstream of the core and directly upstream of the pad ring.
- Converts one read or write request into one complete SPI transaction, then returns a one-cycle ready pulse.
- One transaction outstanding at a time.

Parameters:
- CLK_DIV, 1: SCLK half-period in clk cycles. SCLK = clk/(2*CLK_DIV). Legal range 1..255.
- CMD_READ, 8'h03: SPI read opcode.
- CMD_WRITE, 8'h02: SPI write opcode.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  request strobe, level-sampled.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  8  Neander byte address; sampled with req.
- wdata  input  8  write data; sampled with req.
- rdata  output  8  read data; valid while ready = 1 and held until the next read completes.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  transaction in progress.
- spi_cs_n  output  1  chip select, active low.
- spi_sclk  output  1  serial clock; idles low.
- spi_mosi  output  1  master out.
- spi_miso  input  1  master in.

Behaviour:
- Reset (async, rst_n = 0):
  - spi_cs_n = 1, spi_sclk = 0, spi_mosi = 0.
  - ready = 0, busy = 0, rdata = 8'h00.
  - FSM → IDLE.
  - Asserting reset mid-transaction aborts it immediately; no ready pulse is issued.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On a clk edge with req = 1: latch we, addr, wdata.
  - Load the 32-bit shift register with {opcode, 8'h00, addr, wdata or 8'h00}.
  - busy = 1, go to SHIFT.
  - req is ignored whenever busy = 1.
- SHIFT:
  - Entered on acceptance edge E. From cycle E+1, spi_cs_n = 0.
  - spi_mosi = shift[31] (MSB first); it changes only while spi_sclk is low.
  - Each bit: spi_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - spi_miso is sampled into the low end of the shift register on the clk edge that ends the high phase.
  - The register shifts left on that same edge.
  - 6-bit bit counter: 32 bits in total, spi_cs_n low for exactly 64*CLK_DIV cycles.
  - The bit counter wraps to 0 after bit 31, then the FSM goes to DONE.
- DONE:
  - Lasts one cycle, at E+64*CLK_DIV+1.
  - spi_cs_n = 1, spi_sclk = 0, ready = 1, busy = 0.
  - For a read, rdata = the last 8 sampled bits, MSB first.
  - For a write, rdata is unchanged.
  - Return to IDLE.
  - A new req cannot be accepted before the DONE edge, so spi_cs_n is guaranteed high for at least 2 cycles between transactions.
- spi_sclk is always low whenever spi_cs_n changes.
- Read and write have the same latency.
- req held continuously: back-to-back transactions are accepted at each IDLE edge.
- Address expansion is fixed: SRAM address = {8'h00, addr}.

Optional Feature:
- Macro: SPI_MEM_CACHE_EN.
- Enabled: a single-entry cache with fields valid, tag[7:0], data[7:0].
  - Read hit (valid && tag == addr): no SPI activity; spi_cs_n stays 1; ready = 1 and rdata = data at cycle E+1; busy stays 0.
  - Read miss: normal SPI transaction, and the cache is filled at DONE.
  - Write: normal SPI transaction, and the cache is updated at DONE (write-through).
  - Reset clears valid.
- Disabled: no cache storage is synthesised, and every request performs an SPI transaction.

Test Plan:
- Reset release, then idle 20 cycles → spi_cs_n = 1, spi_sclk = 0, busy = 0, ready never asserted.
- Write addr = 8'h2A, wdata = 8'hC5, CLK_DIV = 1 →
  - MOSI stream on SCLK rising edges = 32'h02_00_2A_C5.
  - spi_cs_n low exactly 64 cycles.
  - ready pulses once at E+65.
- Read addr = 8'h80, SPI model drives 8'h5A in the data phase →
  - MOSI prefix = 24'h03_00_80.
  - rdata = 8'h5A with ready at E+65.
- CLK_DIV = 3, read →
  - SCLK high and low phases are 3 cycles each.
  - spi_cs_n low 192 cycles; ready at E+193.
- Assert rst_n = 0 at bit 10 of a write → spi_cs_n = 1 asynchronously, no ready; the next request completes normally.
- With SPI_MEM_CACHE_EN: write 8'h10 ← 8'h77, then read 8'h10 → ready at E+1, rdata = 8'h77, spi_cs_n stays 1. Then read 8'h11 → full SPI transaction.
